// File: rtl/cpu_pkg.sv
// Shared encodings for the multiply/divide unit: FSM states, op select and divide-by-zero quotient.
// Pure declarations, no logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Wide enough for any supported operand width; the user slices the low WIDTH bits.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the issue logic and the multiply/divide unit.
// Single-cycle start request, one-cycle done pulse, no backpressure.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] Ry;
  logic [WIDTH-1:0] Rb;
  logic [WIDTH-1:0] resultHi;
  logic [WIDTH-1:0] resultLo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op_div, Ry, Rb,
    input  resultHi, resultLo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op_div, Ry, Rb,
    output resultHi, resultLo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// One iteration of the multiply/divide datapath: a radix-2 Booth step or a restoring-division step.
// Purely combinational, zero latency, no backpressure.
module mdu_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] sr,
  input  logic             prev,
  input  logic [WIDTH:0]   operand,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] sr_nxt,
  output logic             prev_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;

  always_comb begin
    sum      = acc;
    sh       = '0;
    acc_nxt  = acc;
    sr_nxt   = sr;
    prev_nxt = prev;
    if (op == OP_MUL) begin
      // Booth pair {sr[0], prev}; acc carries one guard bit so +/- 2^(WIDTH-1) cannot overflow.
      case ({sr[0], prev})
        2'b01:   sum = acc + operand;
        2'b10:   sum = acc - operand;
        default: sum = acc;
      endcase
      acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
      sr_nxt   = {sum[0], sr[WIDTH-1:1]};
      prev_nxt = sr[0];
    end else begin
      sh = {acc[WIDTH-1:0], sr[WIDTH-1]};
      if (sh >= operand) begin
        acc_nxt = sh - operand;
        sr_nxt  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = sh;
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
      end
      prev_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiply/divide, one bit per clock; done pulses 34 cycles after start (1 for divide-by-zero).
// No backpressure: start is accepted only in IDLE and dropped otherwise.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  mul_div_unit_if.slave    md
);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_r;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sr;
  logic             prev;
  logic [WIDTH:0]   operand;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] sr_nxt;
  logic             prev_nxt;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             dz_r;
  logic             done_r;
  logic             start_div0;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic             busy_c;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign start_div0 = md.start && (md.op_div == OP_DIV) && (md.Rb == '0);

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .op       (op_r),
    .acc      (acc),
    .sr       (sr),
    .prev     (prev),
    .operand  (operand),
    .acc_nxt  (acc_nxt),
    .sr_nxt   (sr_nxt),
    .prev_nxt (prev_nxt)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (md.start) state_nxt = start_div0 ? MD_DONE : MD_CALC;
      end
      MD_CALC: begin
        busy_c = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = MD_FIX;
      end
      MD_FIX: begin
        busy_c    = 1'b1;
        state_nxt = MD_DONE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Sign fix-up: multiply passes through, divide restores signs on magnitude results.
  always_comb begin
    fix_hi = acc[WIDTH-1:0];
    fix_lo = sr;
    if (op_r == OP_DIV) begin
      fix_lo = neg_q ? -sr : sr;
      fix_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= '0;
      op_r    <= OP_MUL;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      acc     <= '0;
      sr      <= '0;
      prev    <= 1'b0;
      operand <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      dz_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state == MD_DONE);
      case (state)
        MD_IDLE: begin
          if (md.start) begin
            op_r  <= md.op_div;
            neg_q <= md.Ry[WIDTH-1] ^ md.Rb[WIDTH-1];
            neg_r <= md.Ry[WIDTH-1];
            acc   <= '0;
            prev  <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            if (md.op_div == OP_DIV) begin
              sr      <= mag(md.Ry);
              operand <= {1'b0, mag(md.Rb)};
            end else begin
              sr      <= md.Rb;
              operand <= {md.Ry[WIDTH-1], md.Ry};
            end
            if (start_div0) begin
              res_hi <= md.Ry;
              res_lo <= DIV0_QUOT[WIDTH-1:0];
              dz_r   <= 1'b1;
            end
          end
        end
        MD_CALC: begin
          acc  <= acc_nxt;
          sr   <= sr_nxt;
          prev <= prev_nxt;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        MD_FIX: begin
          res_hi <= fix_hi;
          res_lo <= fix_lo;
          dz_r   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign md.resultHi    = res_hi;
  assign md.resultLo    = res_lo;
  assign md.div_by_zero = dz_r;
  assign md.done        = done_r;
  assign md.busy        = busy_c;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: products, signed quotients/remainders, divide-by-zero,
// ignored restarts and mid-operation clear, all against hand-computed values.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) md ();

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .md  (md)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for done, check latency/results, then check the pulse ends and results hold.
  task automatic do_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
    int   k;
    logic seen;
    md.start  = 1'b1;
    md.op_div = op;
    md.Ry     = a;
    md.Rb     = b;
    tick();
    md.start  = 1'b0;
    md.op_div = ~op;
    md.Ry     = $urandom;
    md.Rb     = $urandom;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      tick();
      k++;
      if (md.done) seen = 1'b1;
    end
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_hi"}, 64'(md.resultHi), 64'(hi));
    check({tag, "_lo"}, 64'(md.resultLo), 64'(lo));
    check({tag, "_dz"}, 64'(md.div_by_zero), 64'(dz));
    check({tag, "_busy"}, 64'(md.busy), 64'(0));
    tick();
    check({tag, "_done_pulse"}, 64'(md.done), 64'(0));
    check({tag, "_hold_lo"}, 64'(md.resultLo), 64'(lo));
  endtask

  initial begin
    int pulses;
    int first_lat;

    clr       = 1'b1;
    md.start  = 1'b0;
    md.op_div = 1'b0;
    md.Ry     = '0;
    md.Rb     = '0;
    repeat (2) tick();
    check("rst_hi", 64'(md.resultHi), 64'(0));
    check("rst_lo", 64'(md.resultLo), 64'(0));
    check("rst_busy", 64'(md.busy), 64'(0));
    check("rst_done", 64'(md.done), 64'(0));
    check("rst_dz", 64'(md.div_by_zero), 64'(0));
    clr = 1'b0;
    tick();

    do_op("mul_6x7",     1'b0, 32'd6,        32'd7,        32'h0000_0000, 32'h0000_002A, 1'b0, 34);
    do_op("mul_m3x5",    1'b0, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
    do_op("mul_min_sq",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34);
    do_op("div_100_7",   1'b1, 32'd100,      32'd7,        32'd2,         32'd14,        1'b0, 34);
    do_op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    do_op("div_7_m2",    1'b1, 32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 34);
    do_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       32'h8000_0000, 1'b0, 34);
    do_op("div_55_0",    1'b1, 32'd55,       32'd0,        32'd55,        32'hFFFF_FFFF, 1'b1, 1);
    do_op("mul_after_dz", 1'b0, 32'd6,       32'd7,        32'h0000_0000, 32'h0000_002A, 1'b0, 34);

    // Second start mid-operation must be ignored.
    md.start  = 1'b1;
    md.op_div = 1'b0;
    md.Ry     = 32'd6;
    md.Rb     = 32'd7;
    tick();
    md.start  = 1'b0;
    pulses    = 0;
    first_lat = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        md.Ry    = 32'd100;
        md.Rb    = 32'd3;
        md.start = 1'b1;
      end else begin
        md.start = 1'b0;
      end
      tick();
      if (md.done) begin
        pulses++;
        if (pulses == 1) first_lat = c;
      end
    end
    check("restart_pulses", 64'(pulses), 64'(1));
    check("restart_lat", 64'(first_lat), 64'(34));
    check("restart_lo", 64'(md.resultLo), 64'(42));

    // Clear in the middle of a divide.
    md.start  = 1'b1;
    md.op_div = 1'b1;
    md.Ry     = 32'd100;
    md.Rb     = 32'd7;
    tick();
    md.start = 1'b0;
    repeat (10) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 64'(md.busy), 64'(0));
    check("clr_done", 64'(md.done), 64'(0));
    check("clr_hi", 64'(md.resultHi), 64'(0));
    check("clr_lo", 64'(md.resultLo), 64'(0));
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (md.done) pulses++;
    end
    check("clr_no_done", 64'(pulses), 64'(0));
    do_op("div_after_clr", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

    // Start coincident with clr is dropped.
    md.start  = 1'b1;
    md.op_div = 1'b0;
    md.Ry     = 32'd6;
    md.Rb     = 32'd7;
    clr       = 1'b1;
    tick();
    md.start = 1'b0;
    clr      = 1'b0;
    check("clr_start_busy", 64'(md.busy), 64'(0));
    repeat (3) tick();
    check("clr_start_idle", 64'(md.busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
